// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-RAM port arbiter.
// Holds the FSM state and grant encodings, the legal read-latency range and the grant-priority helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef enum logic [1:0] {GNT_IF, GNT_MEM_RD, GNT_MEM_WR} grant_t;

    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 4;
    localparam int LAT_CNT_W = $clog2(LAT_MAX + 1);

    // MEM wins unless IF is being forced; a combined read+write request counts as a write.
    function automatic grant_t pick_grant(input logic rd_req, input logic wr_req, input logic force_if);
        if (force_if) return GNT_IF;
        if (wr_req)   return GNT_MEM_WR;
        if (rd_req)   return GNT_MEM_RD;
        return GNT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the single-port RAM.
// slave is the arbiter's view; master is the view of the environment (pipeline stages plus RAM).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              mem_stall;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of MEM grants taken while IF was kept waiting.
// at_max tells the arbiter that IF must win the next grant.
module arb_starve_counter #(
    parameter  int STARVE_MAX = 4,
    localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);
    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == CNT_W'(STARVE_MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store through an issue/wait/done FSM.
// RAM strobes are registered; completion pulses, read data and stalls are decoded combinationally.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input logic                 clk,
    input logic                 rst,
    mem_port_arbiter_if.slave   bus
);
    if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_check
        $error("mem_port_arbiter: LAT outside the supported range");
    end

    localparam logic [LAT_CNT_W-1:0] LAT_RELOAD = LAT_CNT_W'(LAT - 1);

    state_t                 state, state_d;
    grant_t                 grant, grant_d, sel;
    logic [LAT_CNT_W-1:0]   lat_cnt, lat_cnt_d;
    logic                   any_req, take, force_if, at_max;
    logic                   if_granted, mem_granted, done_if, done_mem;
    logic                   ram_en_q, ram_we_q;
    logic [ADDR_W-1:0]      ram_addr_q;
    logic [DATA_W-1:0]      ram_wdata_q;

    assign any_req     = bus.if_req | bus.mem_rd_req | bus.mem_wr_req;
    assign force_if    = at_max & bus.if_req;
    assign sel         = pick_grant(bus.mem_rd_req, bus.mem_wr_req, force_if);
    assign take        = (state == IDLE) && any_req;
    assign if_granted  = take && (sel == GNT_IF);
    assign mem_granted = take && (sel != GNT_IF);

    arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .clr    (~bus.if_req | if_granted),
        .inc    (mem_granted & bus.if_req),
        .at_max (at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= GNT_IF;
            lat_cnt <= '0;
        end else begin
            state   <= state_d;
            grant   <= grant_d;
            lat_cnt <= lat_cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        grant_d   = grant;
        lat_cnt_d = lat_cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (grant == GNT_MEM_WR || LAT == 1) begin
                    state_d = DONE;
                end else begin
                    lat_cnt_d = LAT_RELOAD;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt - 1'b1;
                if (lat_cnt == LAT_CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address and data are captured at grant, so requesters may change them afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q <= take;
            ram_we_q <= take && (sel == GNT_MEM_WR);
            if (take) begin
                ram_addr_q  <= (sel == GNT_IF) ? bus.if_addr : bus.mem_addr;
                ram_wdata_q <= bus.mem_wdata;
            end
        end
    end

    assign done_if  = (state == DONE) && (grant == GNT_IF);
    assign done_mem = (state == DONE) && (grant != GNT_IF);

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;

    assign bus.if_valid  = done_if;
    assign bus.if_rdata  = done_if ? bus.ram_rdata : '0;
    assign bus.mem_valid = done_mem;
    assign bus.mem_rdata = (done_mem && grant == GNT_MEM_RD) ? bus.ram_rdata : '0;

    assign bus.if_stall  = bus.if_req & ~bus.if_valid;
    assign bus.mem_stall = (bus.mem_rd_req | bus.mem_wr_req) & ~bus.mem_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LAT=1 instance driven by a vector table and directed sequences,
// and a LAT=3 instance used for the reset-during-wait case and a randomized run against a schedule model.
module tb_mem_port_arbiter;
    localparam int LAT3       = 3;
    localparam int STARVE_MAX = 4;
    localparam int RND_CYCLES = 3000;

    logic clk = 1'b0;
    logic rst1, rst3;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut1 (
        .clk (clk), .rst (rst1), .bus (bus1)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT3), .STARVE_MAX(STARVE_MAX)) u_dut3 (
        .clk (clk), .rst (rst3), .bus (bus3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] ram_rdata;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifv;
        logic        e_memv;
        logic        e_ifs;
        logic        e_mems;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
        input logic [31:0] ma, input logic [31:0] md, input logic [31:0] rr,
        input logic en, input logic we, input logic [31:0] ea, input logic [31:0] ew,
        input logic ifv, input logic mv, input logic ifs, input logic ms, input logic [31:0] rd);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;   v.mem_rd = mr;  v.mem_wr = mw;
        v.mem_addr = ma; v.mem_wdata = md; v.ram_rdata = rr;
        v.e_en = en;   v.e_we = we;   v.e_addr = ea; v.e_wdata = ew;
        v.e_ifv = ifv; v.e_memv = mv; v.e_ifs = ifs; v.e_mems = ms; v.e_rdata = rd;
        return v;
    endfunction

    task automatic drive1(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                          input logic [31:0] ma, input logic [31:0] md, input logic [31:0] rr);
        bus1.if_req = ir;  bus1.if_addr = ia;  bus1.mem_rd_req = mr; bus1.mem_wr_req = mw;
        bus1.mem_addr = ma; bus1.mem_wdata = md; bus1.ram_rdata = rr;
    endtask

    // Scoreboard state for the randomized LAT=3 run.
    logic [31:0] ref_mem [16];
    logic [31:0] ram_mem [16];

    initial begin
        vec_t        vt[$];
        logic [31:0] issued[$];
        logic [31:0] exp_issue[6];

        rst1 = 1'b1;
        rst3 = 1'b1;
        drive1(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.mem_rd_req = 1'b0; bus3.mem_wr_req = 1'b0;
        bus3.mem_addr = '0; bus3.mem_wdata = '0; bus3.ram_rdata = '0;

        // Reset held 70ns with IF requesting.
        repeat (6) @(negedge clk);
        check("rst_ram_en",   bus1.ram_en,   1'b0);
        check("rst_if_valid", bus1.if_valid, 1'b0);
        check("rst_if_stall", bus1.if_stall, 1'b1);
        check("rst_ram_addr", bus1.ram_addr, 32'h0);
        check("rst_if_rdata", bus1.if_rdata, 32'h0);
        #10;
        rst1 = 1'b0;
        rst3 = 1'b0;
        #1;
        check("rel_ram_en_before_edge", bus1.ram_en, 1'b0);
        @(negedge clk);
        check("rel_ram_en_issue", bus1.ram_en,   1'b1);
        check("rel_ram_addr",     bus1.ram_addr, 32'h40);
        bus1.ram_rdata = 32'h600D_0040;
        @(negedge clk);
        check("rel_if_valid", bus1.if_valid, 1'b1);
        check("rel_if_rdata", bus1.if_rdata, 32'h600D_0040);
        @(posedge clk); #1;
        drive1(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);

        // Cycle-by-cycle vectors for the LAT=1 instance.
        //             ir  if_addr  rd  wr  mem_addr  wdata         ram_rdata      en  we  addr    wdata         ifv mv  ifs ms  rdata
        vt.push_back(mk(1, 32'h40,  0,  0,  32'h0,    32'h0,        32'h1111_1111, 0,  0,  32'h0,  32'h0,        0,  0,  1,  0,  32'h0));
        vt.push_back(mk(1, 32'h40,  0,  0,  32'h0,    32'h0,        32'h1111_1111, 1,  0,  32'h40, 32'h0,        0,  0,  1,  0,  32'h0));
        vt.push_back(mk(1, 32'h40,  0,  0,  32'h0,    32'h0,        32'hDEAD_BEEF, 0,  0,  32'h0,  32'h0,        1,  0,  0,  0,  32'hDEAD_BEEF));
        vt.push_back(mk(0, 32'h0,   0,  0,  32'h0,    32'h0,        32'h1111_1111, 0,  0,  32'h0,  32'h0,        0,  0,  0,  0,  32'h0));
        vt.push_back(mk(1, 32'h44,  1,  0,  32'h100,  32'h0,        32'h2222_2222, 0,  0,  32'h0,  32'h0,        0,  0,  1,  1,  32'h0));
        vt.push_back(mk(1, 32'h44,  1,  0,  32'h100,  32'h0,        32'h2222_2222, 1,  0,  32'h100,32'h0,        0,  0,  1,  1,  32'h0));
        vt.push_back(mk(1, 32'h44,  1,  0,  32'h100,  32'h0,        32'hCAFE_F00D, 0,  0,  32'h0,  32'h0,        0,  1,  1,  0,  32'hCAFE_F00D));
        vt.push_back(mk(1, 32'h44,  0,  0,  32'h0,    32'h0,        32'h2222_2222, 0,  0,  32'h0,  32'h0,        0,  0,  1,  0,  32'h0));
        vt.push_back(mk(1, 32'h44,  0,  0,  32'h0,    32'h0,        32'h2222_2222, 1,  0,  32'h44, 32'h0,        0,  0,  1,  0,  32'h0));
        vt.push_back(mk(1, 32'h44,  0,  0,  32'h0,    32'h0,        32'h0BAD_F00D, 0,  0,  32'h0,  32'h0,        1,  0,  0,  0,  32'h0BAD_F00D));
        vt.push_back(mk(0, 32'h0,   0,  0,  32'h0,    32'h0,        32'h2222_2222, 0,  0,  32'h0,  32'h0,        0,  0,  0,  0,  32'h0));
        vt.push_back(mk(0, 32'h0,   0,  1,  32'h200,  32'h1234_5678,32'h3333_3333, 0,  0,  32'h0,  32'h0,        0,  0,  0,  1,  32'h0));
        vt.push_back(mk(0, 32'h0,   0,  1,  32'h200,  32'h1234_5678,32'h3333_3333, 1,  1,  32'h200,32'h1234_5678,0,  0,  0,  1,  32'h0));
        vt.push_back(mk(0, 32'h0,   0,  1,  32'h200,  32'h1234_5678,32'h3333_3333, 0,  0,  32'h0,  32'h0,        0,  1,  0,  0,  32'h0));
        vt.push_back(mk(0, 32'h0,   0,  0,  32'h0,    32'h0,        32'h3333_3333, 0,  0,  32'h0,  32'h0,        0,  0,  0,  0,  32'h0));
        vt.push_back(mk(0, 32'h0,   1,  1,  32'h204,  32'h0000_55AA,32'h4444_4444, 0,  0,  32'h0,  32'h0,        0,  0,  0,  1,  32'h0));
        vt.push_back(mk(0, 32'h0,   1,  1,  32'h204,  32'h0000_55AA,32'h4444_4444, 1,  1,  32'h204,32'h0000_55AA,0,  0,  0,  1,  32'h0));
        vt.push_back(mk(0, 32'h0,   1,  1,  32'h204,  32'h0000_55AA,32'h4444_4444, 0,  0,  32'h0,  32'h0,        0,  1,  0,  0,  32'h0));
        vt.push_back(mk(0, 32'h0,   0,  0,  32'h0,    32'h0,        32'h4444_4444, 0,  0,  32'h0,  32'h0,        0,  0,  0,  0,  32'h0));

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk); #1;
            drive1(vt[i].if_req, vt[i].if_addr, vt[i].mem_rd, vt[i].mem_wr,
                   vt[i].mem_addr, vt[i].mem_wdata, vt[i].ram_rdata);
            @(negedge clk);
            check($sformatf("vec%0d_ram_en", i),    bus1.ram_en,    vt[i].e_en);
            if (vt[i].e_en) begin
                check($sformatf("vec%0d_ram_we", i),   bus1.ram_we,   vt[i].e_we);
                check($sformatf("vec%0d_ram_addr", i), bus1.ram_addr, vt[i].e_addr);
            end
            if (vt[i].e_en && vt[i].e_we)
                check($sformatf("vec%0d_ram_wdata", i), bus1.ram_wdata, vt[i].e_wdata);
            check($sformatf("vec%0d_if_valid", i),  bus1.if_valid,  vt[i].e_ifv);
            check($sformatf("vec%0d_mem_valid", i), bus1.mem_valid, vt[i].e_memv);
            check($sformatf("vec%0d_if_stall", i),  bus1.if_stall,  vt[i].e_ifs);
            check($sformatf("vec%0d_mem_stall", i), bus1.mem_stall, vt[i].e_mems);
            if (vt[i].e_ifv)  check($sformatf("vec%0d_if_rdata", i),  bus1.if_rdata,  vt[i].e_rdata);
            if (vt[i].e_memv && vt[i].mem_rd && !vt[i].mem_wr)
                check($sformatf("vec%0d_mem_rdata", i), bus1.mem_rdata, vt[i].e_rdata);
        end

        // Starvation: both held high; expect four MEM issues, one forced IF issue, then MEM again.
        @(posedge clk); #1;
        drive1(1'b1, 32'h80, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (bus1.ram_en) begin
                issued.push_back(bus1.ram_addr);
                if (bus1.ram_addr == 32'h80)
                    check("starve_count_after_if_grant", 32'(u_dut1.u_starve.count), 32'h0);
            end
            @(posedge clk); #1;
        end
        exp_issue = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h80, 32'h300};
        check("starve_issue_count", 32'(issued.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < issued.size())
                check($sformatf("starve_issue%0d_addr", k), issued[k], exp_issue[k]);
        end
        drive1(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);

        // LAT=3 read with reset pulsed during WAIT, then a fresh access.
        #1;
        bus3.mem_rd_req = 1'b1; bus3.mem_addr = 32'h500; bus3.ram_rdata = 32'h3333_3333;
        @(negedge clk);
        check("l3_c0_ram_en",    bus3.ram_en,    1'b0);
        check("l3_c0_mem_stall", bus3.mem_stall, 1'b1);
        @(negedge clk);
        check("l3_c1_ram_en",   bus3.ram_en,   1'b1);
        check("l3_c1_ram_we",   bus3.ram_we,   1'b0);
        check("l3_c1_ram_addr", bus3.ram_addr, 32'h500);
        @(negedge clk);
        check("l3_c2_ram_en", bus3.ram_en, 1'b0);
        rst3 = 1'b1;
        #1;
        check("l3_rst_ram_en",    bus3.ram_en,    1'b0);
        check("l3_rst_mem_valid", bus3.mem_valid, 1'b0);
        check("l3_rst_ram_addr",  bus3.ram_addr,  32'h0);
        check("l3_rst_mem_stall", bus3.mem_stall, 1'b1);
        #2;
        rst3 = 1'b0;
        @(negedge clk);
        check("l3_c3_ram_en",    bus3.ram_en,    1'b1);
        check("l3_c3_ram_addr",  bus3.ram_addr,  32'h500);
        check("l3_c3_mem_valid", bus3.mem_valid, 1'b0);
        @(posedge clk); #1;
        bus3.ram_rdata = 32'h4444_4444;
        @(negedge clk);
        check("l3_c4_mem_valid", bus3.mem_valid, 1'b0);
        check("l3_c4_ram_en",    bus3.ram_en,    1'b0);
        @(negedge clk);
        check("l3_c5_mem_valid", bus3.mem_valid, 1'b0);
        @(posedge clk); #1;
        bus3.ram_rdata = 32'h5A5A_1234;
        @(negedge clk);
        check("l3_c6_mem_valid", bus3.mem_valid, 1'b1);
        check("l3_c6_mem_rdata", bus3.mem_rdata, 32'h5A5A_1234);
        check("l3_c6_mem_stall", bus3.mem_stall, 1'b0);
        check("l3_c6_if_valid",  bus3.if_valid,  1'b0);
        @(posedge clk); #1;
        bus3.mem_rd_req = 1'b0;
        @(negedge clk);
        check("l3_c7_mem_valid", bus3.mem_valid, 1'b0);
        check("l3_c7_ram_en",    bus3.ram_en,    1'b0);
        @(posedge clk);

        run_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Randomized run on the LAT=3 instance. The model is a schedule: each grant fixes its issue
    // and completion cycles arithmetically, and a starvation tally decides who wins the next slot.
    task automatic run_random();
        int          next_free = 0;
        int          starve    = 0;
        int          p_who     = 0;   // 0 = IF, 1 = MEM read, 2 = MEM write
        int          p_issue   = -1;
        int          p_done    = -1;
        logic [31:0] p_addr    = '0;
        logic [31:0] p_wdata   = '0;
        logic [31:0] p_data    = '0;
        int          rd_at     = -1;
        logic [31:0] rd_val    = '0;
        logic        n_if = 1'b0, n_rd = 1'b0, n_wr = 1'b0;
        logic [31:0] n_ia = '0, n_ma = '0, n_md = '0;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'hA500_0000 + 32'(i);
            ram_mem[i] = 32'hA500_0000 + 32'(i);
        end

        for (int c = 0; c < RND_CYCLES; c++) begin
            logic exp_en, exp_ifv, exp_mv, granted;
            int   who;

            @(posedge clk); #1;
            bus3.if_req = n_if;  bus3.if_addr = n_ia;
            bus3.mem_rd_req = n_rd; bus3.mem_wr_req = n_wr;
            bus3.mem_addr = n_ma; bus3.mem_wdata = n_md;
            bus3.ram_rdata = (c == rd_at) ? rd_val : (32'hEE00_0000 | 32'(c));
            @(negedge clk);

            exp_en  = (c == p_issue);
            exp_ifv = (c == p_done) && (p_who == 0);
            exp_mv  = (c == p_done) && (p_who != 0);
            check("rnd_ram_en", bus3.ram_en, exp_en);
            if (exp_en) begin
                check("rnd_ram_addr", bus3.ram_addr, p_addr);
                check("rnd_ram_we",   bus3.ram_we,   (p_who == 2));
                if (p_who == 2) check("rnd_ram_wdata", bus3.ram_wdata, p_wdata);
            end
            check("rnd_if_valid",  bus3.if_valid,  exp_ifv);
            check("rnd_mem_valid", bus3.mem_valid, exp_mv);
            if (exp_ifv) check("rnd_if_rdata", bus3.if_rdata, p_data);
            if (exp_mv && p_who == 1) check("rnd_mem_rdata", bus3.mem_rdata, p_data);
            check("rnd_if_stall",  bus3.if_stall,  n_if & ~exp_ifv);
            check("rnd_mem_stall", bus3.mem_stall, (n_rd | n_wr) & ~exp_mv);

            // RAM responder reacting to what the DUT actually drove.
            if (bus3.ram_en) begin
                if (bus3.ram_we) begin
                    ram_mem[bus3.ram_addr[5:2]] = bus3.ram_wdata;
                end else begin
                    rd_at  = c + LAT3;
                    rd_val = ram_mem[bus3.ram_addr[5:2]];
                end
            end

            granted = 1'b0;
            who     = 0;
            if (c >= next_free && (n_if || n_rd || n_wr)) begin
                granted = 1'b1;
                if (n_if && starve == STARVE_MAX) who = 0;
                else if (n_wr)                    who = 2;
                else if (n_rd)                    who = 1;
                else                              who = 0;
                p_who     = who;
                p_issue   = c + 1;
                p_done    = p_issue + ((who == 2) ? 1 : LAT3);
                next_free = p_done + 1;
                p_addr    = (who == 0) ? n_ia : n_ma;
                p_wdata   = n_md;
                if (who == 2) ref_mem[p_addr[5:2]] = n_md;
                else          p_data = ref_mem[p_addr[5:2]];
            end
            if (!n_if)                     starve = 0;
            else if (granted && who == 0)  starve = 0;
            else if (granted)              starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;

            // Requesters: hold until completion, then maybe issue a new request.
            if (exp_ifv) begin
                n_if = ($urandom_range(3) != 0);
                n_ia = 32'h1000 + 32'($urandom_range(15) * 4);
            end else if (!n_if && $urandom_range(2) == 0) begin
                n_if = 1'b1;
                n_ia = 32'h1000 + 32'($urandom_range(15) * 4);
            end
            if (exp_mv || (!n_rd && !n_wr)) begin
                if ($urandom_range(1) == 1) begin
                    case ($urandom_range(2))
                        0:       begin n_rd = 1'b1; n_wr = 1'b0; end
                        1:       begin n_rd = 1'b0; n_wr = 1'b1; end
                        default: begin n_rd = 1'b1; n_wr = 1'b1; end
                    endcase
                    n_ma = 32'h2000 + 32'($urandom_range(15) * 4);
                    n_md = $urandom;
                end else begin
                    n_rd = 1'b0;
                    n_wr = 1'b0;
                end
            end else if (granted && who != 0 && $urandom_range(1) == 1) begin
                // Address/data moving after grant must not disturb the latched access.
                n_ma = 32'h2000 + 32'($urandom_range(15) * 4);
                n_md = $urandom;
            end
        end
    endtask
endmodule
